// File: rtl/link_delay_stage_pkg.sv
// Shared types and constants for the fixed-latency link stage (package link_pkg).
package link_pkg;

  localparam int unsigned LINK_MAX_DELAY = 8;
  localparam int unsigned LINK_DATA_W    = 8;
  // Width that holds 0..LINK_MAX_DELAY beats in flight.
  localparam int unsigned LINK_CNT_W     = $clog2(LINK_MAX_DELAY + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN
  } link_state_e;

  typedef struct packed {
    logic                   valid;
    logic [LINK_DATA_W-1:0] data;
  } link_beat_t;

endpackage

// File: rtl/link_delay_stage_if.sv
// Transmit/receive bundle of the link stage; master = transmitter/checker side, slave = the stage.
interface link_delay_stage_if
  import link_pkg::*;
#(
  parameter int unsigned DATA_W = LINK_DATA_W
);

  logic                  en;
  logic                  tx_valid;
  logic [DATA_W-1:0]     tx_data;
  logic                  rx_valid;
  logic [DATA_W-1:0]     rx_data;
  logic [7:0]            rx_seq;
  logic [LINK_CNT_W-1:0] inflight;
  logic                  busy;
  logic [15:0]           drop_cnt;

  modport master (
    output en, tx_valid, tx_data,
    input  rx_valid, rx_data, rx_seq, inflight, busy, drop_cnt
  );

  modport slave (
    input  en, tx_valid, tx_data,
    output rx_valid, rx_data, rx_seq, inflight, busy, drop_cnt
  );

endinterface

// File: rtl/link_delay_stage_pipe.sv
// DELAY-stage beat shift register (module link_pipe); stage DELAY-1 is the output stage.
module link_pipe
  import link_pkg::*;
#(
  parameter int unsigned DELAY  = 2,
  parameter type         beat_t = link_beat_t
) (
  input  logic  clk,
  input  logic  rst,
  input  beat_t beat_i,
  output beat_t beat_o
);

  beat_t stage_q [DELAY];

  // NOTE: every stage is cleared on reset, not just the valid bits, so beats in
  // flight at reset are lost and the output data reads zero immediately after.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DELAY; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= beat_i;
      for (int i = 1; i < DELAY; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign beat_o = stage_q[DELAY-1];

endmodule

// File: rtl/link_delay_stage.sv
// Fixed-latency link stage: DELAY-cycle beat pipe plus IDLE/ACTIVE/DRAIN control and counters.
// Define LINK_DELAY_ASSERT_EN to compile in the latency/origin/occupancy assertions.
module link_delay_stage
  import link_pkg::*;
#(
  parameter int unsigned DELAY  = 2,            // legal range 1..LINK_MAX_DELAY
  parameter int unsigned DATA_W = LINK_DATA_W
) (
  input logic               clk,
  input logic               rst,
  link_delay_stage_if.slave link
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } beat_t;

  link_state_e           state_q;
  logic [LINK_CNT_W-1:0] inflight_q, inflight_d;
  logic [7:0]            rx_seq_q;
  logic [15:0]           drop_cnt_q;
  logic                  busy_q;
  logic                  accepted;
  beat_t                 beat_in, beat_out;

  assign accepted = link.tx_valid && link.en && (state_q != DRAIN);

  // NOTE: each always_comb assigns every output before any condition, so no latch is inferred.
  always_comb begin
    beat_in.valid = accepted;
    beat_in.data  = accepted ? link.tx_data : '0;
    inflight_d    = inflight_q;
    if (accepted && !beat_out.valid)      inflight_d = inflight_q + 1'b1;
    else if (!accepted && beat_out.valid) inflight_d = inflight_q - 1'b1;
  end

  link_pipe #(
    .DELAY  (DELAY),
    .beat_t (beat_t)
  ) u_pipe (
    .clk    (clk),
    .rst    (rst),
    .beat_i (beat_in),
    .beat_o (beat_out)
  );

  // NOTE: all state here uses non-blocking assignments so every register sees
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      inflight_q <= '0;
      rx_seq_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      if (beat_out.valid) rx_seq_q <= rx_seq_q + 8'd1;
      if (link.tx_valid && !accepted && (drop_cnt_q != 16'hFFFF))
        drop_cnt_q <= drop_cnt_q + 16'd1;

      unique case (state_q)
        IDLE: begin
          if (accepted) begin
            state_q <= ACTIVE;
            busy_q  <= 1'b1;
          end
        end
        ACTIVE: begin
          if (inflight_d == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (!link.en) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          // Enable is ignored here: only an empty pipe ends the drain.
          if (inflight_d == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign link.rx_valid = beat_out.valid;
  assign link.rx_data  = beat_out.data;
  assign link.rx_seq   = rx_seq_q;
  assign link.inflight = inflight_q;
  assign link.busy     = busy_q;
  assign link.drop_cnt = drop_cnt_q;

`ifdef LINK_DELAY_ASSERT_EN
  a_latency: assert property (@(posedge clk) disable iff (rst)
    accepted |-> ##DELAY link.rx_valid)
    $info("link_delay_stage: beat delivered after %0d cycles", DELAY);
  else
    $warning("link_delay_stage: accepted beat missing after %0d cycles", DELAY);

  a_origin: assert property (@(posedge clk) disable iff (rst)
    link.rx_valid |-> $past(accepted, DELAY));

  a_inflight: assert property (@(posedge clk) disable iff (rst)
    inflight_q <= LINK_CNT_W'(DELAY));
`else
  // Default build carries no checking logic; behaviour is unchanged.
`endif

endmodule

// File: tb/tb_link_delay_stage.sv
// Directed bench for link_delay_stage: vector table plus reset, wrap, DELAY=1 and saturation sequences.
module tb_link_delay_stage;
  import link_pkg::*;

  localparam int unsigned DELAY  = 2;
  localparam int unsigned DATA_W = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  link_delay_stage_if #(.DATA_W(DATA_W)) bus  ();
  link_delay_stage_if #(.DATA_W(DATA_W)) bus1 ();

  link_delay_stage #(.DELAY(DELAY), .DATA_W(DATA_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .link (bus)
  );

  link_delay_stage #(.DELAY(1), .DATA_W(DATA_W)) dut1 (
    .clk  (clk),
    .rst  (rst),
    .link (bus1)
  );

  typedef struct {
    logic        en;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [7:0]  rx_seq;
    logic [3:0]  inflight;
    logic        busy;
    logic [15:0] drop;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic rxv, input logic [7:0] rxd,
                           input logic [7:0] seq, input logic [3:0] inf,
                           input logic bsy, input logic [15:0] drop);
    check({tag, " rx_valid"}, 32'(bus.rx_valid), 32'(rxv));
    check({tag, " rx_data"},  32'(bus.rx_data),  32'(rxd));
    check({tag, " rx_seq"},   32'(bus.rx_seq),   32'(seq));
    check({tag, " inflight"}, 32'(bus.inflight), 32'(inf));
    check({tag, " busy"},     32'(bus.busy),     32'(bsy));
    check({tag, " drop_cnt"}, 32'(bus.drop_cnt), 32'(drop));
  endtask

  initial begin
    bit rx_seen;

    //            en    tx    data  | rxv   rxd    seq   inf   busy  drop
    vecs[0]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 8'h00, 8'd0, 4'd1, 1'b1, 16'd0};
    vecs[1]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'hA5, 8'd0, 4'd1, 1'b1, 16'd0};
    vecs[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'd1, 4'd0, 1'b0, 16'd0};
    vecs[3]  = '{1'b1, 1'b1, 8'h10, 1'b0, 8'h00, 8'd1, 4'd1, 1'b1, 16'd0};
    vecs[4]  = '{1'b1, 1'b1, 8'h11, 1'b1, 8'h10, 8'd1, 4'd2, 1'b1, 16'd0};
    vecs[5]  = '{1'b1, 1'b1, 8'h12, 1'b1, 8'h11, 8'd2, 4'd2, 1'b1, 16'd0};
    vecs[6]  = '{1'b0, 1'b1, 8'h13, 1'b1, 8'h12, 8'd3, 4'd1, 1'b1, 16'd1};
    vecs[7]  = '{1'b1, 1'b1, 8'h14, 1'b0, 8'h00, 8'd4, 4'd0, 1'b0, 16'd2};
    vecs[8]  = '{1'b1, 1'b1, 8'h15, 1'b0, 8'h00, 8'd4, 4'd1, 1'b1, 16'd2};
    vecs[9]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h15, 8'd4, 4'd1, 1'b1, 16'd2};
    vecs[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'd5, 4'd0, 1'b0, 16'd2};
    vecs[11] = '{1'b0, 1'b1, 8'h77, 1'b0, 8'h00, 8'd5, 4'd0, 1'b0, 16'd3};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'd5, 4'd0, 1'b0, 16'd3};

    rst           = 1'b1;
    bus.en        = 1'b0;
    bus.tx_valid  = 1'b0;
    bus.tx_data   = '0;
    bus1.en       = 1'b0;
    bus1.tx_valid = 1'b0;
    bus1.tx_data  = '0;
    tick();
    tick();
    check_all("reset", 1'b0, 8'h00, 8'd0, 4'd0, 1'b0, 16'd0);
    rst = 1'b0;

    // Single beat, stream with a one-cycle enable drop, refusals while idle.
    for (int i = 0; i < 13; i++) begin
      bus.en       = vecs[i].en;
      bus.tx_valid = vecs[i].tx_valid;
      bus.tx_data  = vecs[i].tx_data;
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].rx_valid, vecs[i].rx_data, vecs[i].rx_seq,
                vecs[i].inflight, vecs[i].busy, vecs[i].drop);
    end

    // Reset with two beats in flight: they vanish and refusals are cleared.
    bus.en       = 1'b1;
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h40;
    tick();
    bus.tx_data  = 8'h41;
    tick();
    check("pre_rst inflight", 32'(bus.inflight), 32'd2);
    bus.tx_data = 8'h42;
    rst = 1'b1;
    tick();
    check_all("rst_mid", 1'b0, 8'h00, 8'd0, 4'd0, 1'b0, 16'd0);
    rst          = 1'b0;
    bus.tx_valid = 1'b0;
    rx_seen      = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.rx_valid) rx_seen = 1'b1;
    end
    check("post_rst rx_seen", 32'(rx_seen), 32'd0);
    check_all("post_rst", 1'b0, 8'h00, 8'd0, 4'd0, 1'b0, 16'd0);

    // Continuous stream from a clean state: two-cycle lag, sequence wraps at beat 257.
    bus.tx_valid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      bus.tx_data = 8'(k);
      tick();
      if (k == 0) begin
        check("stream k0 rx_valid", 32'(bus.rx_valid), 32'd0);
      end else begin
        check($sformatf("stream k%0d rx_valid", k), 32'(bus.rx_valid), 32'd1);
        check($sformatf("stream k%0d rx_data", k),  32'(bus.rx_data),  32'((k - 1) % 256));
        check($sformatf("stream k%0d rx_seq", k),   32'(bus.rx_seq),   32'((k - 1) % 256));
        check($sformatf("stream k%0d inflight", k), 32'(bus.inflight), 32'd2);
      end
    end
    bus.tx_valid = 1'b0;
    tick();
    tick();
    tick();
    check_all("stream_end", 1'b0, 8'h00, 8'd44, 4'd0, 1'b0, 16'd0);

    // DELAY=1: stage 0 is the output stage.
    bus1.en       = 1'b1;
    bus1.tx_valid = 1'b1;
    bus1.tx_data  = 8'h3C;
    tick();
    check("d1 b0 rx_valid", 32'(bus1.rx_valid), 32'd1);
    check("d1 b0 rx_data",  32'(bus1.rx_data),  32'h3C);
    check("d1 b0 inflight", 32'(bus1.inflight), 32'd1);
    check("d1 b0 busy",     32'(bus1.busy),     32'd1);
    bus1.tx_data = 8'h3D;
    tick();
    check("d1 b1 rx_data",  32'(bus1.rx_data),  32'h3D);
    check("d1 b1 rx_seq",   32'(bus1.rx_seq),   32'd1);
    check("d1 b1 inflight", 32'(bus1.inflight), 32'd1);
    bus1.tx_valid = 1'b0;
    tick();
    check("d1 end rx_valid", 32'(bus1.rx_valid), 32'd0);
    check("d1 end rx_seq",   32'(bus1.rx_seq),   32'd2);
    check("d1 end inflight", 32'(bus1.inflight), 32'd0);
    check("d1 end busy",     32'(bus1.busy),     32'd0);
    bus1.en = 1'b0;

    // Link disabled under constant traffic: refusal counter saturates, nothing delivered.
    bus.en       = 1'b0;
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'hEE;
    rx_seen      = 1'b0;
    for (int i = 1; i <= 70000; i++) begin
      tick();
      if (bus.rx_valid) rx_seen = 1'b1;
      if (i == 65534) check("sat 65534", 32'(bus.drop_cnt), 32'hFFFE);
      if (i == 65535) check("sat 65535", 32'(bus.drop_cnt), 32'hFFFF);
    end
    check("sat final drop_cnt", 32'(bus.drop_cnt), 32'hFFFF);
    check("sat rx_seen",        32'(rx_seen),      32'd0);
    check("sat busy",           32'(bus.busy),     32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
